// File: rtl/fifo_axis_upsizer.sv
// Packs RATIO first-word-fall-through FIFO words into one AXI-Stream beat with tkeep/tlast.
// Optional idle-timeout close of partial beats: define FIFO_AXIS_UPSIZER_TIMEOUT_EN.
module fifo_axis_upsizer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4,
    parameter int PKT_BEATS  = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [DATA_WIDTH-1:0]       fifo_data,
    input  logic                        fifo_empty,
    output logic                        fifo_pull,
    input  logic                        flush,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [DATA_WIDTH*RATIO-1:0] m_axis_tdata,
    output logic [RATIO-1:0]            m_axis_tkeep,
    output logic                        m_axis_tlast
);

    localparam int CW = $clog2(RATIO) + 1;
    localparam int BW = $clog2(PKT_BEATS) + 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(RATIO - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_BEATS - 1);

    if (RATIO < 2 || PKT_BEATS < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("fifo_axis_upsizer: RATIO must be >= 2, PKT_BEATS and TIMEOUT >= 1");
    end

    typedef enum logic {FILL, SEND} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   beat_cnt;
    logic            pull;
    logic            close_req;
    logic            close_now;
    logic            go_send;
    logic            timeout_hit;

    always_comb begin
        state_nxt = state;
        pull      = 1'b0;
        close_now = 1'b0;
        go_send   = 1'b0;
        case (state)
            FILL: begin
                pull      = aresetn && !fifo_empty;
                // a word pulled in the closing cycle joins the closed beat
                close_now = close_req && ((cnt != '0) || pull);
                go_send   = close_now || (pull && (cnt == LAST_SLOT));
                if (go_send) state_nxt = SEND;
            end
            SEND: begin
                if (m_axis_tready) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= FILL;
        else          state <= state_nxt;
    end

`ifdef FIFO_AXIS_UPSIZER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT) + 1;
    logic [IW-1:0] idle_cnt;

    always_ff @(posedge aclk) begin
        if (!aresetn)
            idle_cnt <= '0;
        else if (state != FILL || pull || go_send)
            idle_cnt <= '0;
        else if (cnt != '0 && fifo_empty)
            idle_cnt <= idle_cnt + IW'(1);
    end

    assign timeout_hit = (state == FILL) && (cnt != '0) && (idle_cnt == IW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign close_req = flush || timeout_hit;

    // beat assembly and output hold
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt          <= '0;
            beat_cnt     <= '0;
            m_axis_tdata <= '0;
            m_axis_tkeep <= '0;
            m_axis_tlast <= 1'b0;
        end else if (state == FILL) begin
            if (pull) begin
                for (int i = 0; i < RATIO; i++) begin
                    if (cnt == CW'(i)) begin
                        m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
                        m_axis_tkeep[i]                          <= 1'b1;
                    end
                end
                cnt <= cnt + CW'(1);
            end
            if (go_send) m_axis_tlast <= close_now || (beat_cnt == LAST_BEAT);
        end else if (m_axis_tready) begin
            m_axis_tdata <= '0;
            m_axis_tkeep <= '0;
            m_axis_tlast <= 1'b0;
            cnt          <= '0;
            beat_cnt     <= m_axis_tlast ? '0 : beat_cnt + BW'(1);
        end
    end

    assign fifo_pull     = pull;
    assign m_axis_tvalid = (state == SEND);

endmodule
